// File: rtl/param_memory.sv
// Parametrised single-port data memory with a hardware init sequencer that
// writes the power-up pattern one word per clock, registered reads and range checks.
module param_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int INIT_MODE  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  Write,
    input  logic                  Read,
    input  logic                  Init,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  ReadValid,
    output logic                  AddrError,
    output logic                  Ready
);

    localparam int IDX_W     = $clog2(DEPTH);
    localparam int MEM_WORDS = 1 << IDX_W;
    localparam logic [ADDR_WIDTH-1:0] HALF_A  = ADDR_WIDTH'(DEPTH / 2);
    localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        S_INIT,
        S_IDLE
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
    logic                    read_valid_q, read_valid_d;
    logic                    addr_error_q, addr_error_d;
    logic                    ready_q, ready_d;

    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];
    logic                    mem_we;
    logic [IDX_W-1:0]        mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic                    addr_ok;
    logic [ADDR_WIDTH-1:0]   half_idx;
    logic [DATA_WIDTH-1:0]   idx_ext;
    logic [DATA_WIDTH-1:0]   init_word;

    assign addr_ok = {1'b0, Address} < DEPTH_X;

    // Split ramp: lower half counts up, upper half counts down from zero.
    always_comb begin
        half_idx = init_cnt_q - HALF_A;
        idx_ext  = DATA_WIDTH'(half_idx);
        if (INIT_MODE == 0) begin
            init_word = '0;
        end else if (init_cnt_q < HALF_A) begin
            init_word = DATA_WIDTH'(init_cnt_q);
        end else begin
            init_word = (~idx_ext) + DATA_WIDTH'(1);
        end
    end

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        addr_error_d = 1'b0;
        ready_d      = ready_q;
        mem_we       = 1'b0;
        mem_waddr    = Address[IDX_W-1:0];
        mem_wdata    = WriteData;

        unique case (state_q)
            S_INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = init_cnt_q[IDX_W-1:0];
                mem_wdata  = init_word;
                init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                if (init_cnt_q == LAST_A) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (Init) begin
                    state_d    = S_INIT;
                    init_cnt_d = '0;
                    ready_d    = 1'b0;
                end else if (Write) begin
                    mem_we       = addr_ok;
                    addr_error_d = !addr_ok;
                end else if (Read) begin
                    if (addr_ok) begin
                        read_data_d  = mem[Address[IDX_W-1:0]];
                        read_valid_d = 1'b1;
                    end else begin
                        addr_error_d = 1'b1;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_INIT;
            init_cnt_q   <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            addr_error_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            addr_error_q <= addr_error_d;
            ready_q      <= ready_d;
        end
    end

    // NOTE: the array has no reset branch; the sequencer fills it after every reset.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign ReadData  = read_data_q;
    assign ReadValid = read_valid_q;
    assign AddrError = addr_error_q;
    assign Ready     = ready_q;

endmodule

// File: tb/tb_param_memory.sv
// Directed bench for param_memory: default build plus a 16-bit/8-deep zero-init build,
// with read results checked through an expected-data queue.
module tb_param_memory;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset = 1'b1, a_write = 1'b0, a_read = 1'b0, a_init = 1'b0;
    logic [7:0]  a_addr = '0, a_wdata = '0, a_rdata;
    logic        a_rvalid, a_err, a_ready;

    logic        b_reset = 1'b1, b_write = 1'b0, b_read = 1'b0, b_init = 1'b0;
    logic [7:0]  b_addr = '0;
    logic [15:0] b_wdata = '0, b_rdata;
    logic        b_rvalid, b_err, b_ready;

    param_memory dut_a (
        .clk(clk), .reset(a_reset), .Address(a_addr), .WriteData(a_wdata),
        .Write(a_write), .Read(a_read), .Init(a_init),
        .ReadData(a_rdata), .ReadValid(a_rvalid), .AddrError(a_err), .Ready(a_ready)
    );

    param_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(8), .INIT_MODE(0)) dut_b (
        .clk(clk), .reset(b_reset), .Address(b_addr), .WriteData(b_wdata),
        .Write(b_write), .Read(b_read), .Init(b_init),
        .ReadData(b_rdata), .ReadValid(b_rvalid), .AddrError(b_err), .Ready(b_ready)
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q [$];
    logic [7:0]  model [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        int v;
        v = (i < 16) ? i : (256 - (i - 16)) % 256;
        return v[7:0];
    endfunction

    task automatic model_init();
        for (int i = 0; i < 32; i++) model[i] = pat(i);
    endtask

    task automatic wait_ready(input bit use_b, input int exp_n, input string tag);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(use_b ? b_ready : a_ready) && n < 100);
        check(tag, n, exp_n);
    endtask

    task automatic write_a(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        a_addr = addr; a_wdata = data; a_write = 1'b1; a_read = 1'b0; a_init = 1'b0;
        @(posedge clk); #1;
        a_write = 1'b0;
        if (addr < 32) model[addr] = data;
        check("wr_rvalid", a_rvalid, 0);
        check("wr_err", a_err, addr >= 32);
    endtask

    task automatic read_a(input logic [7:0] addr);
        logic [7:0] prev;
        prev = a_rdata;
        @(negedge clk);
        a_addr = addr; a_read = 1'b1; a_write = 1'b0; a_init = 1'b0;
        if (addr < 32) exp_q.push_back({8'h00, model[addr]});
        @(posedge clk); #1;
        a_read = 1'b0;
        if (addr < 32) begin
            check("rd_valid", a_rvalid, 1);
            if (a_rvalid && exp_q.size() > 0) check("rd_data", a_rdata, exp_q.pop_front());
        end else begin
            check("oor_valid", a_rvalid, 0);
            check("oor_err", a_err, 1);
            check("oor_rdata", a_rdata, prev);
        end
    endtask

    task automatic burst_a();
        for (int i = 0; i < 32; i++) read_a(8'(i));
    endtask

    task automatic read_b(input logic [7:0] addr);
        @(negedge clk);
        b_addr = addr; b_read = 1'b1;
        if (addr < 8) exp_q.push_back(16'h0000);
        @(posedge clk); #1;
        b_read = 1'b0;
        if (addr < 8) begin
            check("b_rd_valid", b_rvalid, 1);
            if (b_rvalid && exp_q.size() > 0) check("b_rd_data", b_rdata, exp_q.pop_front());
        end else begin
            check("b_oor_err", b_err, 1);
            check("b_oor_valid", b_rvalid, 0);
        end
    endtask

    initial begin
        int rv_seen;
        model_init();

        // Power-up: two reset clocks, then 32 init clocks.
        repeat (2) begin @(posedge clk); #1; end
        check("rst_ready", a_ready, 0);
        check("rst_rvalid", a_rvalid, 0);
        check("rst_err", a_err, 0);
        check("rst_rdata", a_rdata, 0);
        @(negedge clk); a_reset = 1'b0;
        wait_ready(0, 32, "powerup_latency");

        // Spot values of the split ramp.
        model[3] = 8'h03; model[16] = 8'h00; model[17] = 8'hFF; model[31] = 8'hF1;
        read_a(3); read_a(16); read_a(17); read_a(31);
        burst_a();

        // Write then read back-to-back.
        write_a(5, 8'hA5);
        read_a(5);
        burst_a();

        // Write+Read collision: write wins, read dropped.
        @(negedge clk);
        a_addr = 7; a_wdata = 8'h3C; a_write = 1'b1; a_read = 1'b1;
        @(posedge clk); #1;
        a_write = 1'b0; a_read = 1'b0;
        model[7] = 8'h3C;
        check("coll_rvalid", a_rvalid, 0);
        read_a(7);

        // Init+Write: write dropped, full re-init.
        @(negedge clk);
        a_addr = 7; a_wdata = 8'h55; a_write = 1'b1; a_init = 1'b1;
        @(posedge clk); #1;
        a_write = 1'b0; a_init = 1'b0;
        check("init_ready_drop", a_ready, 0);
        wait_ready(0, 32, "reinit_latency");
        model_init();
        read_a(7);
        burst_a();

        // Out-of-range read, idle clear, out-of-range write.
        read_a(40);
        @(negedge clk); a_read = 1'b0; a_write = 1'b0;
        @(posedge clk); #1;
        check("idle_err_clear", a_err, 0);
        write_a(32, 8'h77);
        burst_a();

        // Reset mid-init with reads held high during INIT.
        write_a(9, 8'h99);
        @(negedge clk); a_reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); a_reset = 1'b0; a_read = 1'b1; a_addr = 3;
        rv_seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (a_rvalid || a_err) rv_seen++;
        end
        check("init_ignores_read", rv_seen, 0);
        @(negedge clk); a_reset = 1'b1; a_read = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); a_reset = 1'b0;
        wait_ready(0, 32, "midinit_latency");
        model_init();
        burst_a();

        // 16-bit, 8-deep, zero-init build.
        check("b_rst_ready", b_ready, 0);
        @(negedge clk); b_reset = 1'b0;
        wait_ready(1, 8, "b_latency");
        for (int i = 0; i < 8; i++) read_b(8'(i));
        read_b(8);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
